// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: control bundle layout, NOP encoding and field encodings
// used by the decode/execute pipeline registers.
package rv32i_pkg;

  localparam int unsigned CTRL_W = 10;

  // Bit positions inside the control bundle
  localparam int unsigned CTRL_REGWRITE   = 9;
  localparam int unsigned CTRL_BRANCH_EN  = 8;
  localparam int unsigned CTRL_MEMWRITE   = 7;
  localparam int unsigned CTRL_MEMREAD    = 6;
  localparam int unsigned CTRL_MEMTOREG_H = 5;
  localparam int unsigned CTRL_MEMTOREG_L = 4;
  localparam int unsigned CTRL_ALUOP_H    = 3;
  localparam int unsigned CTRL_ALUOP_L    = 2;
  localparam int unsigned CTRL_ALUSRC_H   = 1;
  localparam int unsigned CTRL_ALUSRC_L   = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = 10'h000;

  typedef enum logic [1:0] {
    AluOpAdd    = 2'b00,
    AluOpBranch = 2'b01,
    AluOpRtype  = 2'b10,
    AluOpItype  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    AluSrcReg = 2'b00,
    AluSrcImm = 2'b01,
    AluSrcPc  = 2'b10,
    AluSrcRsv = 2'b11
  } alu_src_e;

  typedef enum logic [1:0] {
    WbAlu    = 2'b00,
    WbMem    = 2'b01,
    WbPcPlus = 2'b10,
    WbRsv    = 2'b11
  } mem_to_reg_e;

  // An instruction slot is a bubble when it carries no control or is not valid
  function automatic logic is_bubble(input logic [CTRL_W-1:0] ctrl, input logic valid);
    return (ctrl == CTRL_NOP) || !valid;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decode-side inputs and execute-side registered outputs.
interface id_ex_pipe_reg_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned CNT_W  = 16
);

  logic              ip_stall;
  logic              ip_flush;
  logic [CTRL_W-1:0] ip_ctrl;
  logic              ip_valid;
  logic [XLEN-1:0]   ip_pc;
  logic [XLEN-1:0]   ip_rs1_data;
  logic [XLEN-1:0]   ip_rs2_data;
  logic [XLEN-1:0]   ip_imm;
  logic [4:0]        ip_rs1;
  logic [4:0]        ip_rs2;
  logic [4:0]        ip_rd;
  logic [2:0]        ip_funct3;
  logic              ip_funct7b5;
  logic              ip_cnt_clr;

  logic [CTRL_W-1:0] op_ctrl;
  logic              op_RegWrite;
  logic              op_Branch_en;
  logic              op_MemWrite;
  logic              op_MemRead;
  logic [1:0]        op_MemtoReg;
  logic [1:0]        op_ALUOp;
  logic [1:0]        op_ALUSrc;
  logic              op_valid;
  logic [XLEN-1:0]   op_pc;
  logic [XLEN-1:0]   op_rs1_data;
  logic [XLEN-1:0]   op_rs2_data;
  logic [XLEN-1:0]   op_imm;
  logic [4:0]        op_rs1;
  logic [4:0]        op_rs2;
  logic [4:0]        op_rd;
  logic [2:0]        op_funct3;
  logic              op_funct7b5;
  logic [CNT_W-1:0]  op_bubble_cnt;

  modport master (
    output ip_stall, ip_flush, ip_ctrl, ip_valid, ip_pc, ip_rs1_data, ip_rs2_data, ip_imm,
           ip_rs1, ip_rs2, ip_rd, ip_funct3, ip_funct7b5, ip_cnt_clr,
    input  op_ctrl, op_RegWrite, op_Branch_en, op_MemWrite, op_MemRead, op_MemtoReg,
           op_ALUOp, op_ALUSrc, op_valid, op_pc, op_rs1_data, op_rs2_data, op_imm,
           op_rs1, op_rs2, op_rd, op_funct3, op_funct7b5, op_bubble_cnt
  );

  modport slave (
    input  ip_stall, ip_flush, ip_ctrl, ip_valid, ip_pc, ip_rs1_data, ip_rs2_data, ip_imm,
           ip_rs1, ip_rs2, ip_rd, ip_funct3, ip_funct7b5, ip_cnt_clr,
    output op_ctrl, op_RegWrite, op_Branch_en, op_MemWrite, op_MemRead, op_MemtoReg,
           op_ALUOp, op_ALUSrc, op_valid, op_pc, op_rs1_data, op_rs2_data, op_imm,
           op_rs1, op_rs2, op_rd, op_funct3, op_funct7b5, op_bubble_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble insert and a saturating
// count of bubbles entering the EX stage.
module id_ex_pipe_reg
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = rv32i_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_pipe_reg_if.slave bus
);

  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;
  logic              r_funct7b5;

  logic              w_inc;
  logic [CNT_W-1:0]  w_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.ip_flush) begin
      // Flush loads an all-zero bubble, identical to the reset image
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
    end else if (!bus.ip_stall) begin
      r_ctrl     <= bus.ip_ctrl;
      r_valid    <= bus.ip_valid && (bus.ip_ctrl != CTRL_NOP);
      r_pc       <= bus.ip_pc;
      r_rs1_data <= bus.ip_rs1_data;
      r_rs2_data <= bus.ip_rs2_data;
      r_imm      <= bus.ip_imm;
      r_rs1      <= bus.ip_rs1;
      r_rs2      <= bus.ip_rs2;
      r_rd       <= bus.ip_rd;
      r_funct3   <= bus.ip_funct3;
      r_funct7b5 <= bus.ip_funct7b5;
    end
  end

  // A flush counts even when stalled, since it overrides the hold
  assign w_inc = bus.ip_flush || (!bus.ip_stall && is_bubble(bus.ip_ctrl, bus.ip_valid));

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.ip_cnt_clr),
    .inc   (w_inc),
    .count (w_cnt)
  );

  assign bus.op_ctrl       = r_ctrl;
  assign bus.op_RegWrite   = r_ctrl[CTRL_REGWRITE];
  assign bus.op_Branch_en  = r_ctrl[CTRL_BRANCH_EN];
  assign bus.op_MemWrite   = r_ctrl[CTRL_MEMWRITE];
  assign bus.op_MemRead    = r_ctrl[CTRL_MEMREAD];
  assign bus.op_MemtoReg   = r_ctrl[CTRL_MEMTOREG_H:CTRL_MEMTOREG_L];
  assign bus.op_ALUOp      = r_ctrl[CTRL_ALUOP_H:CTRL_ALUOP_L];
  assign bus.op_ALUSrc     = r_ctrl[CTRL_ALUSRC_H:CTRL_ALUSRC_L];
  assign bus.op_valid      = r_valid;
  assign bus.op_pc         = r_pc;
  assign bus.op_rs1_data   = r_rs1_data;
  assign bus.op_rs2_data   = r_rs2_data;
  assign bus.op_imm        = r_imm;
  assign bus.op_rs1        = r_rs1;
  assign bus.op_rs2        = r_rs2;
  assign bus.op_rd         = r_rd;
  assign bus.op_funct3     = r_funct3;
  assign bus.op_funct7b5   = r_funct7b5;
  assign bus.op_bubble_cnt = w_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized bench for id_ex_pipe_reg: a 16-bit-counter and a 4-bit-counter instance share
// stimulus and are compared against a slot-level reference model.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus
  logic        s_stall = 0, s_flush = 0, s_valid = 0, s_f7 = 0, s_clr = 0;
  logic [9:0]  s_ctrl = 0;
  logic [31:0] s_pc = 0, s_d1 = 0, s_d2 = 0, s_imm = 0;
  logic [4:0]  s_rs1 = 0, s_rs2 = 0, s_rd = 0;
  logic [2:0]  s_f3 = 0;

  id_ex_pipe_reg_if #(.XLEN(32), .CTRL_W(10), .CNT_W(16)) bus16 ();
  id_ex_pipe_reg_if #(.XLEN(32), .CTRL_W(10), .CNT_W(4))  bus4 ();

  assign bus16.ip_stall = s_stall;   assign bus4.ip_stall = s_stall;
  assign bus16.ip_flush = s_flush;   assign bus4.ip_flush = s_flush;
  assign bus16.ip_ctrl = s_ctrl;     assign bus4.ip_ctrl = s_ctrl;
  assign bus16.ip_valid = s_valid;   assign bus4.ip_valid = s_valid;
  assign bus16.ip_pc = s_pc;         assign bus4.ip_pc = s_pc;
  assign bus16.ip_rs1_data = s_d1;   assign bus4.ip_rs1_data = s_d1;
  assign bus16.ip_rs2_data = s_d2;   assign bus4.ip_rs2_data = s_d2;
  assign bus16.ip_imm = s_imm;       assign bus4.ip_imm = s_imm;
  assign bus16.ip_rs1 = s_rs1;       assign bus4.ip_rs1 = s_rs1;
  assign bus16.ip_rs2 = s_rs2;       assign bus4.ip_rs2 = s_rs2;
  assign bus16.ip_rd = s_rd;         assign bus4.ip_rd = s_rd;
  assign bus16.ip_funct3 = s_f3;     assign bus4.ip_funct3 = s_f3;
  assign bus16.ip_funct7b5 = s_f7;   assign bus4.ip_funct7b5 = s_f7;
  assign bus16.ip_cnt_clr = s_clr;   assign bus4.ip_cnt_clr = s_clr;

  id_ex_pipe_reg #(.XLEN(32), .CTRL_W(10), .CNT_W(16)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  id_ex_pipe_reg #(.XLEN(32), .CTRL_W(10), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // Reference model: contents of the EX slot plus bubble tallies
  typedef struct packed {
    logic [9:0]  ctrl;
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } slot_t;

  slot_t m_slot;
  int    m_bubbles;   // unbounded tally since last clear/reset

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int bits);
    int lim;
    lim = (1 << bits) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic check_all(input string tag);
    logic [9:0] c;
    c = m_slot.ctrl;
    check({tag, ".ctrl"},     bus16.op_ctrl, c);
    check({tag, ".regwr"},    bus16.op_RegWrite, c[9]);
    check({tag, ".br"},       bus16.op_Branch_en, c[8]);
    check({tag, ".memwr"},    bus16.op_MemWrite, c[7]);
    check({tag, ".memrd"},    bus16.op_MemRead, c[6]);
    check({tag, ".m2r"},      bus16.op_MemtoReg, c[5:4]);
    check({tag, ".aluop"},    bus16.op_ALUOp, c[3:2]);
    check({tag, ".alusrc"},   bus16.op_ALUSrc, c[1:0]);
    check({tag, ".valid"},    bus16.op_valid, m_slot.valid);
    check({tag, ".pc"},       bus16.op_pc, m_slot.pc);
    check({tag, ".rs1d"},     bus16.op_rs1_data, m_slot.d1);
    check({tag, ".rs2d"},     bus16.op_rs2_data, m_slot.d2);
    check({tag, ".imm"},      bus16.op_imm, m_slot.imm);
    check({tag, ".regs"},     {bus16.op_rs1, bus16.op_rs2, bus16.op_rd},
          {m_slot.rs1, m_slot.rs2, m_slot.rd});
    check({tag, ".funct"},    {bus16.op_funct3, bus16.op_funct7b5}, {m_slot.f3, m_slot.f7});
    check({tag, ".cnt16"},    bus16.op_bubble_cnt, sat(m_bubbles, 16));
    check({tag, ".cnt4"},     bus4.op_bubble_cnt, sat(m_bubbles, 4));
    check({tag, ".ctrl4"},    bus4.op_ctrl, c);
  endtask

  // Apply one clock edge with the currently driven inputs, update model, check at edge+1
  task automatic cycle(input string tag);
    slot_t nxt;
    int    nb;
    nxt = m_slot;
    nb  = m_bubbles;
    if (s_flush) begin
      nxt = '0;
    end else if (!s_stall) begin
      nxt = '{ctrl: s_ctrl, valid: s_valid && (s_ctrl != 0), pc: s_pc, d1: s_d1, d2: s_d2,
               imm: s_imm, rs1: s_rs1, rs2: s_rs2, rd: s_rd, f3: s_f3, f7: s_f7};
    end
    if (s_clr) nb = 0;
    else if (s_flush || (!s_stall && (s_ctrl == 0 || !s_valid))) nb = nb + 1;
    @(posedge clk);
    #1;
    m_slot    = nxt;
    m_bubbles = nb;
    check_all(tag);
  endtask

  task automatic randomize_fields();
    s_pc  = $urandom; s_d1 = $urandom; s_d2 = $urandom; s_imm = $urandom;
    s_rs1 = 5'($urandom); s_rs2 = 5'($urandom); s_rd = 5'($urandom);
    s_f3  = 3'($urandom); s_f7 = 1'($urandom);
  endtask

  task automatic idle_inputs();
    s_stall = 0; s_flush = 0; s_clr = 0;
  endtask

  // Asynchronous reset asserted mid-cycle, released on the falling edge
  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_slot    = '0;
    m_bubbles = 0;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    m_slot    = '0;
    m_bubbles = 0;
    #3;
    check_all("reset0");
    @(negedge clk);
    reset = 1'b0;

    // Load
    idle_inputs();
    randomize_fields();
    s_ctrl = 10'h2A5; s_pc = 32'h0000_0040; s_rd = 5'd5; s_valid = 1;
    cycle("load");
    check("t2.ctrl", bus16.op_ctrl, 10'h2A5);
    check("t2.regwr", bus16.op_RegWrite, 1'b1);
    check("t2.alusrc", bus16.op_ALUSrc, 2'b01);
    check("t2.pc", bus16.op_pc, 32'h40);
    check("t2.valid", bus16.op_valid, 1'b1);

    // Stall for 3 cycles with a different bundle presented
    s_stall = 1; s_ctrl = 10'h3FF;
    randomize_fields();
    repeat (3) cycle("stall");
    check("t3.ctrl", bus16.op_ctrl, 10'h2A5);
    check("t3.cnt", bus16.op_bubble_cnt, 16'd0);

    // Flush together with stall
    s_flush = 1;
    cycle("flush_stall");
    check("t4.ctrl", bus16.op_ctrl, 10'h000);
    check("t4.rd", bus16.op_rd, 5'd0);
    check("t4.cnt", bus16.op_bubble_cnt, 16'd1);

    // Mid-flush reset, then NOP-mux bubbles
    mid_reset("reset_flush");
    idle_inputs();
    s_ctrl = 10'h000; s_valid = 1;
    repeat (4) cycle("nop");
    check("t5.cnt", bus16.op_bubble_cnt, 16'd4);
    check("t5.valid", bus16.op_valid, 1'b0);
    s_clr = 1;
    cycle("clr");
    check("t5.clr", bus16.op_bubble_cnt, 16'd0);

    // Saturation of the 4-bit instance, with clear during stall afterwards
    s_clr = 0;
    repeat (20) cycle("sat");
    check("t6.cnt4", bus4.op_bubble_cnt, 4'hF);
    check("t6.cnt16", bus16.op_bubble_cnt, 16'd20);
    s_stall = 1; s_clr = 1;
    cycle("clr_stall");
    check("t6.clr4", bus4.op_bubble_cnt, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s_stall = ($urandom_range(0, 3) == 0);
      s_flush = ($urandom_range(0, 6) == 0);
      s_clr   = ($urandom_range(0, 40) == 0);
      s_valid = ($urandom_range(0, 4) != 0);
      s_ctrl  = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
      randomize_fields();
      if ($urandom_range(0, 80) == 0) begin
        mid_reset("rand_reset");
      end else begin
        cycle("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
